arb_mux: RTL and testbench
==========================

# arb_mux

Parametrised N-channel streaming multiplexer with a valid/ready handshake on every input and on the output. It contains a round-robin arbiter, optional packet locking and a registered output stage. It is the handshaked successor to the plain select-driven mux. It sits in front of shared datapath resources (ALU ports, result buses) where several producers compete for one consumer.

## Interface
- `N`, 4: number of input channels, ≥1.
- `W`, 32: data width per channel.
- `LOCK`, 1: 1 holds the grant until the granted channel transfers a beat with `last`=1; 0 re-arbitrates every beat.
- `SW`, derived as max(1, clog2(N)): width of the channel index (localparam).

Ports:
- `clk_i`  in  1  single clock, rising edge.
- `rst_ni`  in  1  asynchronous, active-low reset.
- `ce_i`  in  1  clock enable. Low freezes all state and forces `in_ready_o`=0.
- `in_valid_i`  in  N  per-channel valid.
- `in_data_i`  in  N*W  flattened payloads; channel k is at bits [k*W +: W].
- `in_last_i`  in  N  per-channel end-of-packet flag.
- `in_ready_o`  out  N  per-channel ready; at most one bit is high.
- `out_valid_o`  out  1  output beat valid.
- `out_ready_i`  in  1  downstream ready.
- `out_data_o`  out  W  registered payload.
- `out_last_o`  out  1  registered last flag.
- `out_sel_o`  out  SW  index of the channel that supplied the current beat.

## Operation
- `accept` = `ce_i` & (~`out_valid_o` | `out_ready_i`). The output register loads whenever `accept` and the granted channel is valid.
- Round-robin pointer `ptr` (SW bits):
  - When not locked, grant `g` goes to the first channel with `in_valid_i` set, searching cyclically from `ptr` upward.
  - No valid channel means no grant.
- Lock (LOCK=1):
  - Set when a beat with `last`=0 transfers.
  - Cleared when a beat with `last`=1 transfers.
  - While set, `g` is the locked channel regardless of other requests. If that channel is not valid, no transfer occurs (bubble) and other channels stay blocked.
- `in_ready_o[g]` = `accept` & `grant_valid`; all other bits are 0. A transfer on channel k occurs when `in_valid_i[k]` & `in_ready_o[k]`.
- On a transfer:
  - `out_data_o`, `out_last_o` and `out_sel_o` load channel g; `out_valid_o` ← 1.
  - `ptr` ← (g+1) mod N, when LOCK=0 or the beat has `last`=1. Otherwise `ptr` is unchanged.
- Output consumption: when `out_valid_o` & `out_ready_i` & `ce_i` and no new transfer occurs, `out_valid_o` ← 0.
- Output hold: while `out_valid_o`=1 and `out_ready_i`=0, all out_* signals stay stable.
- `ce_i`=0: no state changes, `in_ready_o`=0, and `out_ready_i` is ignored (no consumption).
- Reset values: `out_valid_o`=0, `out_data_o`=0, `out_last_o`=0, `out_sel_o`=0, `ptr`=0, lock=0. `in_ready_o` is forced to 0 while `rst_ni`=0.
- Wrap-around: for N not a power of two, `ptr` wraps from N-1 to 0 and never holds a value ≥N.
- N=1 is legal: `out_sel_o` is always 0 and the block reduces to a registered handshake stage.
- With LOCK=0, `in_last_i` is passed through to `out_last_o` but does not affect arbitration.

## Timing
- Latency: 1 cycle from an input handshake to `out_valid_o`.
- Throughput: 1 beat per cycle with `out_ready_i` held high.
- `in_ready_o` is combinational from `out_ready_i`, `ce_i`, all `in_valid_i`, `ptr` and lock. There is no combinational path from input to output data.
- Reset assertion clears outputs asynchronously, with no clock needed.

## Structure
- Shared util header holds the clog2 function and the max(1, ·) width helper used for SW.
- One sub-module, `rr_arbiter`:
  - Parameter N.
  - Inputs: requests, `ptr`, lock-enable, locked index.
  - Outputs: one-hot grant, encoded index, `grant_valid`.
- The top level holds `ptr`, the lock register and the output stage.

## Test plan
- N=4, LOCK=0, all four channels valid, `out_ready_i`=1: `out_sel_o` runs 0,1,2,3,0,… one beat per cycle, with the first `out_valid_o` one cycle after the first handshake.
- Backpressure: hold `out_ready_i`=0 for 3 cycles while `out_valid_o`=1. `out_data_o` and `out_sel_o` stay stable and `in_ready_o`=0000. On release, the next channel follows in the following cycle.
- LOCK=1, channel 1 sends a 3-beat packet with channel 2 valid throughout:
  - `out_sel_o` = 1,1,1,2.
  - Dropping `in_valid_i[1]` for one cycle mid-packet produces a bubble, and channel 2 is not granted.
- N=3, only channels 0 and 2 valid, LOCK=0: grant sequence 0,2,0,2, confirming `ptr` wraps from 2 to 0.
- `ce_i` low for 2 cycles with pending requests: `in_ready_o`=0, outputs and `ptr` unchanged, and `out_ready_i` is ignored. Operation resumes identically afterwards.
- Reset mid-packet (lock set, `out_valid_o`=1): `out_valid_o` drops immediately. After release, `ptr`=0, lock is clear, and with all channels valid, channel 0 wins first.

Source files
------------

// File: rtl/arb_mux_pkg.sv
// Shared helpers for the arb_mux slice: ceil-log2 and the channel-index width.
package arb_mux_pkg;

    localparam int MAX_LOG = 31;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < MAX_LOG; i++) begin
            r = ((32'sd1 <<< i) < n) ? (i + 1) : r;
        end
        return r;
    endfunction

    // Channel index is at least one bit wide so N=1 still has a usable select.
    function automatic int sw_width(input int n);
        return (clog2(n) > 1) ? clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant search from a pointer, with an optional forced (locked) grant.
module rr_arbiter
    import arb_mux_pkg::*;
#(
    parameter int N  = 4,
    parameter int SW = sw_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    input  logic          lock_en,
    input  logic [SW-1:0] lock_idx,
    output logic [N-1:0]  gnt_oh,
    output logic [SW-1:0] gnt_idx,
    output logic          gnt_valid
);

    int cand_s;

    // Search downward in offset so the request closest to ptr is the last (winning) assignment.
    always_comb begin
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        cand_s    = 0;
        if (lock_en) begin
            gnt_idx   = lock_idx;
            gnt_valid = req[lock_idx];
        end else begin
            for (int i = N - 1; i >= 0; i--) begin
                cand_s    = (int'(ptr) + i) % N;
                gnt_idx   = req[cand_s] ? SW'(cand_s) : gnt_idx;
                gnt_valid = gnt_valid | req[cand_s];
            end
        end
    end

    // One-hot form of the granted index.
    always_comb begin
        gnt_oh = '0;
        for (int k = 0; k < N; k++) begin
            gnt_oh[k] = gnt_valid & (int'(gnt_idx) == k);
        end
    end

endmodule

// File: rtl/arb_mux.sv
// N-channel valid/ready multiplexer: round-robin arbitration, optional packet lock,
// registered output stage.
module arb_mux
    import arb_mux_pkg::*;
#(
    parameter int N    = 4,
    parameter int W    = 32,
    parameter int LOCK = 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   ce_i,
    input  logic [N-1:0]           in_valid_i,
    input  logic [N*W-1:0]         in_data_i,
    input  logic [N-1:0]           in_last_i,
    output logic [N-1:0]           in_ready_o,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [W-1:0]           out_data_o,
    output logic                   out_last_o,
    output logic [sw_width(N)-1:0] out_sel_o
);

    localparam int            SW       = sw_width(N);
    localparam logic [SW-1:0] LAST_IDX = SW'(N - 1);
    localparam logic          LOCK_EN  = (LOCK != 32'sd0);

    logic [SW-1:0] ptr_r;
    logic          lock_r;
    logic          out_valid_r;
    logic [W-1:0]  out_data_r;
    logic          out_last_r;
    logic [SW-1:0] out_sel_r;

    logic [N-1:0]  gnt_oh_s;
    logic [SW-1:0] gnt_idx_s;
    logic          gnt_valid_s;
    logic          accept_s;
    logic          xfer_s;
    logic [W-1:0]  sel_data_s;
    logic          sel_last_s;
    logic [SW-1:0] ptr_nxt_s;

    // While locked, the held out_sel register is the locked channel.
    rr_arbiter #(
        .N  (N),
        .SW (SW)
    ) u_arb (
        .req       (in_valid_i),
        .ptr       (ptr_r),
        .lock_en   (lock_r),
        .lock_idx  (out_sel_r),
        .gnt_oh    (gnt_oh_s),
        .gnt_idx   (gnt_idx_s),
        .gnt_valid (gnt_valid_s)
    );

    // Handshake decode; gnt_valid already implies the granted channel is valid.
    always_comb begin
        accept_s   = ce_i & (~out_valid_r | out_ready_i);
        xfer_s     = accept_s & gnt_valid_s;
        in_ready_o = (rst_ni & xfer_s) ? gnt_oh_s : '0;
        ptr_nxt_s  = (gnt_idx_s == LAST_IDX) ? '0 : (gnt_idx_s + SW'(1));
    end

    // AND-OR payload select driven by the one-hot grant.
    always_comb begin
        sel_data_s = '0;
        sel_last_s = 1'b0;
        for (int k = 0; k < N; k++) begin
            sel_data_s = sel_data_s | (in_data_i[k*W +: W] & {W{gnt_oh_s[k]}});
            sel_last_s = sel_last_s | (in_last_i[k] & gnt_oh_s[k]);
        end
    end

    // Output stage, round-robin pointer and packet lock; ce_i low freezes everything.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_r       <= '0;
            lock_r      <= 1'b0;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_last_r  <= 1'b0;
            out_sel_r   <= '0;
        end else if (ce_i) begin
            if (xfer_s) begin
                out_valid_r <= 1'b1;
                out_data_r  <= sel_data_s;
                out_last_r  <= sel_last_s;
                out_sel_r   <= gnt_idx_s;
                lock_r      <= LOCK_EN & ~sel_last_s;
                if (!LOCK_EN || sel_last_s) begin
                    ptr_r <= ptr_nxt_s;
                end
            end else if (out_valid_r && out_ready_i) begin
                out_valid_r <= 1'b0;
            end
        end
    end

    assign out_valid_o = out_valid_r;
    assign out_data_o  = out_data_r;
    assign out_last_o  = out_last_r;
    assign out_sel_o   = out_sel_r;

endmodule

// File: tb/tb_arb_mux.sv
// Randomized scoreboard bench for arb_mux in three configurations (N4/LOCK0, N4/LOCK1, N3/LOCK0).
module tb_arb_mux;

    typedef struct {
        logic [31:0] d;
        logic        l;
        int          s;
    } beat_t;

    localparam int NCFG = 3;
    localparam int CFG_N [NCFG] = '{4, 4, 3};
    localparam int CFG_L [NCFG] = '{0, 1, 0};
    localparam int DENS_TAB [5] = '{100, 60, 30, 90, 45};
    localparam int RDY_TAB  [5] = '{100, 40, 75, 100, 20};

    logic clk = 1'b0;
    logic rst_n;
    logic ce;
    logic drain;
    logic done_chk;
    int   dens;
    int   rdy_pct;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    for (genvar gi = 0; gi < NCFG; gi++) begin : g_cfg
        localparam int NN  = CFG_N[gi];
        localparam int LK  = CFG_L[gi];
        localparam int SWW = (NN > 1) ? $clog2(NN) : 1;

        logic [NN-1:0]    in_valid;
        logic [NN*32-1:0] in_data;
        logic [NN-1:0]    in_last;
        logic [NN-1:0]    in_ready;
        logic             out_valid;
        logic             out_ready;
        logic [31:0]      out_data;
        logic             out_last;
        logic [SWW-1:0]   out_sel;

        int    m_ptr  = 0;
        int    m_lidx = 0;
        bit    m_lock = 1'b0;
        bit    m_ov   = 1'b0;
        beat_t m_q[$];

        arb_mux #(.N(NN), .W(32), .LOCK(LK)) u_dut (
            .clk_i       (clk),
            .rst_ni      (rst_n),
            .ce_i        (ce),
            .in_valid_i  (in_valid),
            .in_data_i   (in_data),
            .in_last_i   (in_last),
            .in_ready_o  (in_ready),
            .out_valid_o (out_valid),
            .out_ready_i (out_ready),
            .out_data_o  (out_data),
            .out_last_o  (out_last),
            .out_sel_o   (out_sel)
        );

        // Reset-state values while the initial reset is held.
        initial begin
            #3;
            chk($sformatf("cfg%0d rst out_valid", gi), 64'(out_valid), 64'd0);
            chk($sformatf("cfg%0d rst out_data", gi), 64'(out_data), 64'd0);
            chk($sformatf("cfg%0d rst out_last", gi), 64'(out_last), 64'd0);
            chk($sformatf("cfg%0d rst out_sel", gi), 64'(out_sel), 64'd0);
            chk($sformatf("cfg%0d rst in_ready", gi), 64'(in_ready), 64'd0);
        end

        // Stimulus plus reference model: decides each cycle's grant from the rules and queues the beat.
        initial begin
            int          g;
            bit          gv;
            bit          acc;
            int          c;
            logic [NN-1:0] exp_rdy;
            logic [NN-1:0] mask;
            beat_t       b;
            in_valid  = '0;
            in_data   = '0;
            in_last   = '0;
            out_ready = 1'b0;
            forever begin
                @(negedge clk);
                if (drain) begin
                    in_valid  = '0;
                    out_ready = 1'b1;
                end else begin
                    for (int k = 0; k < NN; k++) begin
                        in_valid[k]         = ($urandom_range(0, 99) < dens);
                        in_last[k]          = ($urandom_range(0, 2) == 0);
                        in_data[k*32 +: 32] = $urandom;
                    end
                    out_ready = ($urandom_range(0, 99) < rdy_pct);
                end
                #1;
                if (!rst_n) begin
                    chk($sformatf("cfg%0d in_ready in reset", gi), 64'(in_ready), 64'd0);
                end else begin
                    chk($sformatf("cfg%0d out_valid", gi), 64'(out_valid), 64'(m_ov));
                    acc = ce && (!m_ov || out_ready);
                    g   = 0;
                    gv  = 1'b0;
                    if (m_lock) begin
                        g  = m_lidx;
                        gv = in_valid[g];
                    end else begin
                        for (int o = 0; o < NN; o++) begin
                            c = (m_ptr + o) % NN;
                            if (!gv && in_valid[c]) begin
                                g  = c;
                                gv = 1'b1;
                            end
                        end
                    end
                    exp_rdy = '0;
                    if (acc && gv) exp_rdy[g] = 1'b1;
                    mask = '1;
                    if (m_lock && !in_valid[g]) mask[g] = 1'b0;
                    chk($sformatf("cfg%0d in_ready", gi), 64'(in_ready & mask), 64'(exp_rdy & mask));
                    if (acc && gv) begin
                        b.d = in_data[g*32 +: 32];
                        b.l = in_last[g];
                        b.s = g;
                        m_q.push_back(b);
                        m_ov = 1'b1;
                        if (LK == 0 || in_last[g]) m_ptr = (g + 1) % NN;
                        if (LK != 0) begin
                            m_lock = !in_last[g];
                            m_lidx = g;
                        end
                    end else if (m_ov && out_ready && ce) begin
                        m_ov = 1'b0;
                    end
                end
            end
        end

        // Asynchronous reset: model forgets everything; outputs must clear without a clock.
        initial begin
            forever begin
                @(negedge rst_n);
                m_q.delete();
                m_ptr  = 0;
                m_lidx = 0;
                m_lock = 1'b0;
                m_ov   = 1'b0;
                #1;
                chk($sformatf("cfg%0d async rst out_valid", gi), 64'(out_valid), 64'd0);
                chk($sformatf("cfg%0d async rst out_sel", gi), 64'(out_sel), 64'd0);
                chk($sformatf("cfg%0d async rst out_data", gi), 64'(out_data), 64'd0);
            end
        end

        // Monitor: each consumed output beat is compared with the oldest expected beat.
        initial begin
            beat_t e;
            forever begin
                @(negedge clk);
                #3;
                if (rst_n && ce && out_valid && out_ready) begin
                    if (m_q.size() == 0) begin
                        chk($sformatf("cfg%0d unexpected beat", gi), 64'd1, 64'd0);
                    end else begin
                        e = m_q.pop_front();
                        chk($sformatf("cfg%0d out_data", gi), 64'(out_data), 64'(e.d));
                        chk($sformatf("cfg%0d out_last", gi), 64'(out_last), 64'(e.l));
                        chk($sformatf("cfg%0d out_sel", gi), 64'(out_sel), 64'(e.s));
                    end
                end
            end
        end

        // End of run: every expected beat delivered and the output idle.
        initial begin
            wait (done_chk);
            chk($sformatf("cfg%0d leftover beats", gi), 64'(m_q.size()), 64'd0);
            chk($sformatf("cfg%0d idle out_valid", gi), 64'(out_valid), 64'd0);
        end
    end

    // Global sequencing: reset, randomized phases, a mid-run reset, drain, summary.
    initial begin
        rst_n    = 1'b0;
        ce       = 1'b0;
        drain    = 1'b0;
        done_chk = 1'b0;
        dens     = 100;
        rdy_pct  = 100;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        ce    = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            dens    = DENS_TAB[(cyc / 300) % 5];
            rdy_pct = RDY_TAB[(cyc / 300) % 5];
            ce      = (cyc < 40) ? 1'b1 : ($urandom_range(0, 9) != 0);
            if (cyc == 1502) rst_n = 1'b1;
            if (cyc == 1500) begin
                #2;
                rst_n = 1'b0;
            end
        end
        drain = 1'b1;
        ce    = 1'b1;
        repeat (12) @(negedge clk);
        done_chk = 1'b1;
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
